// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator with a 2-entry
// skid buffer between fetch and the decode/execute register.
//
// Ports
//   i_clk, i_rst_n      clock, async active-low reset
//   i_flush             sync flush: drops both entries and any same-cycle input
//   i_valid/o_ready     upstream handshake (o_ready = skid entry empty)
//   i_instruction,i_tag instruction word and sideband tag
//   o_valid/i_ready     downstream handshake
//   o_imm,o_fmt         XLEN immediate and format (0 NONE,1 I,2 S,3 B,4 U,5 J,6 Z)
//   o_illegal,o_tag     illegal flag and tag of the output entry
//   o_illegal_cnt       saturating count of accepted illegal instructions
//
// Build option: define IMM_GEN_ZICSR_EN to decode CSR immediate forms of
// SYSTEM (funct3[2]=1) as fmt Z with imm = zext(rs1 field).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instruction,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_imm,
  output logic [2:0]        o_fmt,
  output logic              o_illegal,
  output logic [TAG_W-1:0]  o_tag,
  output logic [CNT_W-1:0]  o_illegal_cnt
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
`endif

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t      dec, main_q, skid_q;
  logic        main_vld, skid_vld;
  logic [31:0] imm32;
  logic [31:0] inst;
  logic        accept, drain;
  logic [CNT_W-1:0] cnt_q;

  assign inst = i_instruction;

  // Immediates are built sign-extended to 32 bits first, then widened to
  // XLEN with a signed cast; the Z form has a zero top bit so it stays zext.
  always_comb begin
    imm32       = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    if (inst[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (inst[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: begin
          dec.fmt = FMT_I;
          imm32   = {{20{inst[31]}}, inst[31:20]};
        end
        7'b0100011: begin
          dec.fmt = FMT_S;
          imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end
        7'b1100011: begin
          dec.fmt = FMT_B;
          imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec.fmt = FMT_U;
          imm32   = {inst[31:12], 12'b0};
        end
        7'b1101111: begin
          dec.fmt = FMT_J;
          imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        7'b0110011, 7'b0001111: ;
        7'b1110011: begin
`ifdef IMM_GEN_ZICSR_EN
          if (inst[14]) begin
            dec.fmt = FMT_Z;
            imm32   = {27'b0, inst[19:15]};
          end
`endif
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    dec.imm = XLEN'($signed(imm32));
    dec.tag = i_tag;
  end

  assign o_ready = ~skid_vld;
  assign o_valid = main_vld;
  assign accept  = i_valid & o_ready;
  assign drain   = main_vld & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      cnt_q    <= '0;
    end else if (i_flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (accept && dec.illegal && !(&cnt_q))
        cnt_q <= cnt_q + CNT_W'(1);
      if (drain) begin
        // Skid full implies o_ready=0, so no accept can collide here.
        if (skid_vld) begin
          main_q   <= skid_q;
          skid_vld <= 1'b0;
        end else if (accept) begin
          main_q   <= dec;
        end else begin
          main_vld <= 1'b0;
        end
      end else if (accept) begin
        if (!main_vld) begin
          main_q   <= dec;
          main_vld <= 1'b1;
        end else begin
          skid_q   <= dec;
          skid_vld <= 1'b1;
        end
      end
    end
  end

  assign o_imm         = main_q.imm;
  assign o_fmt         = main_q.fmt;
  assign o_illegal     = main_q.illegal;
  assign o_tag         = main_q.tag;
  assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share
// stimulus; accepted instructions push a reference result, the output monitor
// compares and pops on each output handshake.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst_n, flush, valid, ready;
  logic [31:0] instr;
  logic [7:0]  tag;

  logic        o_ready32, o_valid32, o_ill32;
  logic [31:0] o_imm32;
  logic [2:0]  o_fmt32;
  logic [7:0]  o_tag32;
  logic [15:0] o_cnt32;
  logic        o_ready64, o_valid64, o_ill64;
  logic [63:0] o_imm64;
  logic [2:0]  o_fmt64;
  logic [7:0]  o_tag64;
  logic [15:0] o_cnt64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready32),
    .i_instruction(instr), .i_tag(tag), .o_valid(o_valid32), .i_ready(ready),
    .o_imm(o_imm32), .o_fmt(o_fmt32), .o_illegal(o_ill32), .o_tag(o_tag32),
    .o_illegal_cnt(o_cnt32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready64),
    .i_instruction(instr), .i_tag(tag), .o_valid(o_valid64), .i_ready(ready),
    .o_imm(o_imm64), .o_fmt(o_fmt64), .o_illegal(o_ill64), .o_tag(o_tag64),
    .o_illegal_cnt(o_cnt64));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  exp_t        q[$];
  logic [15:0] cnt_m = '0;
  int          tests = 0;
  int          fails = 0;

  function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endfunction

  // Reference decode: immediates assembled as integer values from field
  // weights, then wrapped into the signed range of the immediate's width.
  function automatic exp_t model(logic [31:0] in, logic [7:0] tg);
    exp_t  e;
    longint v = 0;
    e.fmt = 3'd0; e.ill = 1'b0; e.tag = tg;
    if (in[1:0] != 2'b11) e.ill = 1'b1;
    else case (in[6:0])
      7'h13, 7'h03, 7'h67: begin
        e.fmt = 3'd1; v = longint'(in[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        e.fmt = 3'd2; v = longint'(in[31:25]) * 32 + longint'(in[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        e.fmt = 3'd3;
        v = longint'(in[31]) * 4096 + longint'(in[7]) * 2048 +
            longint'(in[30:25]) * 32 + longint'(in[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4; v = longint'(in[31:12]) * 4096;
        if (v >= 64'sd2147483648) v -= 64'sd4294967296;
      end
      7'h6F: begin
        e.fmt = 3'd5;
        v = longint'(in[31]) * 1048576 + longint'(in[19:12]) * 4096 +
            longint'(in[20]) * 2048 + longint'(in[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      7'h33, 7'h0F: ;
      7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
        if (in[14]) begin e.fmt = 3'd6; v = longint'(in[19:15]); end
`endif
      end
      default: e.ill = 1'b1;
    endcase
    e.imm = 64'(v);
    return e;
  endfunction

  // Input side: record every accepted instruction.
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) q.delete();
      else if (valid && o_ready32) begin
        exp_t e;
        e = model(instr, tag);
        q.push_back(e);
        if (e.ill && cnt_m != 16'hFFFF) cnt_m++;
      end
    end
  end

  // Output side: occupancy-derived handshake, counter and head-of-queue check.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("o_valid32", 64'(o_valid32), 64'(q.size() > 0));
      chk("o_ready32", 64'(o_ready32), 64'(q.size() < 2));
      chk("o_valid64", 64'(o_valid64), 64'(q.size() > 0));
      chk("o_ready64", 64'(o_ready64), 64'(q.size() < 2));
      chk("cnt32", 64'(o_cnt32), 64'(cnt_m));
      chk("cnt64", 64'(o_cnt64), 64'(cnt_m));
      if (o_valid32 && q.size() > 0) begin
        chk("imm32", 64'(o_imm32), {32'b0, q[0].imm[31:0]});
        chk("imm64", o_imm64, q[0].imm);
        chk("fmt32", 64'(o_fmt32), 64'(q[0].fmt));
        chk("fmt64", 64'(o_fmt64), 64'(q[0].fmt));
        chk("ill", 64'(o_ill32), 64'(q[0].ill));
        chk("tag32", 64'(o_tag32), 64'(q[0].tag));
        chk("tag64", 64'(o_tag64), 64'(q[0].tag));
        if (ready && !flush) void'(q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [7:0] tg,
                       input logic rdy, input logic fl);
    valid = v; instr = ins; tag = tg; ready = rdy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [12];

  initial begin
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
            7'h33, 7'h0F, 7'h73, 7'h73};
    rst_n = 1'b1; flush = 0; valid = 0; ready = 1; instr = '0; tag = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(o_valid32), 64'd0);
    chk("rst_ready", 64'(o_ready32), 64'd1);
    chk("rst_imm", o_imm64, 64'd0);
    chk("rst_fmt", 64'(o_fmt32), 64'd0);
    chk("rst_ill", 64'(o_ill32), 64'd0);
    chk("rst_tag", 64'(o_tag32), 64'd0);
    chk("rst_cnt", 64'(o_cnt32), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed formats
    drive(1, 32'hFFF00093, 8'h11, 1, 0);
    chk("addi_imm32", 64'(o_imm32), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(o_fmt32), 64'd1);
    chk("addi_imm64", o_imm64, 64'hFFFFFFFFFFFFFFFF);
    drive(1, 32'hFE000EE3, 8'h12, 1, 0);
    chk("beq_imm32", 64'(o_imm32), 64'hFFFFFFFC);
    chk("beq_fmt", 64'(o_fmt32), 64'd3);
    drive(1, 32'hFF9FF06F, 8'h13, 1, 0);
    chk("jal_imm32", 64'(o_imm32), 64'hFFFFFFF8);
    chk("jal_fmt", 64'(o_fmt32), 64'd5);
    drive(1, 32'h800000B7, 8'h14, 1, 0);
    chk("lui_imm64", o_imm64, 64'hFFFFFFFF80000000);
    chk("lui_fmt", 64'(o_fmt64), 64'd4);
    drive(1, 32'h300FD073, 8'h15, 1, 0);
`ifdef IMM_GEN_ZICSR_EN
    chk("csr_imm", o_imm64, 64'h1F);
    chk("csr_fmt", 64'(o_fmt32), 64'd6);
`else
    chk("csr_imm", o_imm64, 64'h0);
    chk("csr_fmt", 64'(o_fmt32), 64'd0);
`endif
    chk("csr_ill", 64'(o_ill32), 64'd0);
    drive(0, 32'h0, 8'h0, 1, 0);

    // Back-pressure: tags 1,2 fill main+skid, tag 3 waits.
    drive(1, 32'h00100093, 8'd1, 0, 0);
    drive(1, 32'h00200093, 8'd2, 0, 0);
    chk("hold_ready", 64'(o_ready32), 64'd0);
    drive(1, 32'h00300093, 8'd3, 0, 0);
    chk("hold_tag", 64'(o_tag32), 64'd1);
    drive(1, 32'h00300093, 8'd3, 1, 0);
    chk("rel_tag2", 64'(o_tag32), 64'd2);
    drive(1, 32'h00300093, 8'd3, 1, 0);
    drive(0, 32'h0, 8'h0, 1, 0);
    chk("rel_tag3", 64'(o_tag32), 64'd3);
    drive(0, 32'h0, 8'h0, 1, 0);

    // Illegal count and flush
    drive(1, 32'h0, 8'h21, 1, 0);
    drive(1, 32'h0, 8'h22, 1, 0);
    chk("ill_flag", 64'(o_ill32), 64'd1);
    chk("ill_imm", o_imm64, 64'd0);
    chk("ill_cnt", 64'(o_cnt32), 64'd2);
    drive(1, 32'h0, 8'h23, 1, 1);
    chk("flush_valid", 64'(o_valid32), 64'd0);
    chk("flush_cnt", 64'(o_cnt32), 64'd2);

    // Random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 11)];
      if (i == 1500) begin
        rst_n = 1'b0;
        q.delete();
        cnt_m = '0;
        @(posedge clk); #1;
        chk("mid_rst_valid", 64'(o_valid32), 64'd0);
        chk("mid_rst_cnt", 64'(o_cnt64), 64'd0);
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 9) < 7, ins, 8'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end
    drive(0, 32'h0, 8'h0, 1, 0);
    drive(0, 32'h0, 8'h0, 1, 0);
    drive(0, 32'h0, 8'h0, 1, 0);
    chk("drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised RV32I/RV64I immediate generator that sits between fetch and the decode/execute register. Covers all base formats (I, S, B, U, J) with architecturally correct bit placement and XLEN sign extension, and reports the decoded format and illegal opcodes. Transfers use valid/ready on both sides, buffered by a 2-entry skid stage so that downstream stalls never drop an instruction. It also counts illegal encodings for debug.

## Interface
Parameters:
- XLEN, 32: immediate width; legal values 32 or 64.
- TAG_W, 8: width of the sideband tag (PC index or ROB id) carried alongside each instruction.
- CNT_W, 16: width of the illegal-opcode counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  synchronous flush; discards all buffered entries.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  block can accept; registered (= skid entry empty).
- i_instruction  in  32  raw instruction word.
- i_tag  in  TAG_W  sideband, returned unchanged on o_tag.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts.
- o_imm  out  XLEN  extended immediate.
- o_fmt  out  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR uimm), 7 reserved.
- o_illegal  out  1  opcode unsupported or inst[1:0]!=2'b11.
- o_tag  out  TAG_W  tag of the output entry.
- o_illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Combinational decode of opcode inst[6:0]:
  - I: 0010011, 0000011, 1100111. imm = sext(inst[31:20]).
  - S: 0100011. imm = sext({inst[31:25], inst[11:7]}).
  - B: 1100011. imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: 0110111, 0010111. imm = sext({inst[31:12], 12'b0}).
  - J: 1101111. imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - NONE, legal: 0110011, 0001111, 1110011 (but see Configuration). imm = 0.
  - Any other opcode, or inst[1:0]!=11: fmt NONE, imm 0, illegal 1. No X is ever driven.
- sext extends from the immediate's top bit to XLEN.
- Storage is a main output register plus one skid register, with FIFO order preserved.
  - Accept when i_valid && o_ready.
  - Output consumed when o_valid && i_ready.
- Accept while main is empty, or while main is draining with the skid empty: the decoded entry loads main.
- Accept while main is full and not draining: the entry loads skid.
- Main drains while skid is full: skid moves to main.
- Illegal counter: +1 per accepted illegal instruction; saturates at all-ones; not incremented for entries discarded by a flush in the same cycle.
- i_flush: at the next edge both entries are invalidated and any same-cycle input is discarded. Counter is retained.

## Timing
- Latency: 1 cycle from accept to o_valid. Throughput: 1 instruction/cycle when i_ready=1.
- o_ready falls the cycle after the skid fills, and rises the cycle after the skid empties.
- Outputs do not change while o_valid && !i_ready.
- Reset values (asynchronous assert, synchronous-safe deassert):
  - o_valid=0, o_ready=1
  - o_imm=0, o_fmt=0, o_illegal=0
  - o_tag=0, o_illegal_cnt=0
- Reset mid-transfer drops both entries. No output handshake completes in that cycle.
- Flush has priority over accept and drain in the same cycle.

## Configuration
- IMM_GEN_ZICSR_EN defined: SYSTEM (1110011) with funct3[2]=1 gives fmt Z, imm = zext(inst[19:15]). Other SYSTEM encodings stay NONE, imm 0.
- IMM_GEN_ZICSR_EN undefined: all SYSTEM encodings give fmt NONE, imm 0, legal.

## Test plan
- 0xFFF00093 (addi x1,x0,-1), XLEN=32: one cycle later o_imm=0xFFFFFFFF, o_fmt=1, o_illegal=0.
- 0xFE000EE3 (beq -4) -> o_imm=0xFFFFFFFC, fmt 3. 0xFF9FF06F (jal -8) -> o_imm=0xFFFFFFF8, fmt 5.
- XLEN=64, 0x800000B7 (lui 0x80000) -> o_imm=0xFFFFFFFF80000000, fmt 4.
- Hold i_ready=0 and offer 3 instructions with tags 1,2,3 back-to-back:
  - tags 1 and 2 are accepted, then o_ready=0;
  - release i_ready: outputs appear in order 1,2,3 with no loss or duplication.
- 0x00000000 accepted twice -> o_illegal=1, imm 0, o_illegal_cnt=2. Next cycle, i_flush with a valid input -> o_valid=0, count stays 2.
- 0x300FD073 (csrrwi x0,0x300,31): with IMM_GEN_ZICSR_EN -> o_imm=0x1F, fmt 6; without it -> imm 0, fmt 0, illegal 0.
